// File: rtl/dbg_reg_ctrl.sv
// Debug-side register file initiator: halts the CPU, borrows the register file
// controls for one cycle to read or write Rn, then acknowledges.
module dbg_reg_ctrl #(
  parameter int HALT_TIMEOUT = 64,
  parameter int TMO_W        = 7
) (
  input  logic        mclk,
  input  logic        puc_n,
  input  logic        dbg_req,
  input  logic        dbg_wr,
  input  logic [3:0]  dbg_addr,
  input  logic [15:0] dbg_wdata,
  input  logic        dbg_halt_keep,
  output logic        dbg_ack,
  output logic        dbg_err,
  output logic [15:0] dbg_rdata,
  output logic        dbg_busy,
  input  logic        cpu_halted,
  input  logic [15:0] reg_src,
  output logic        dbg_halt_req,
  output logic        dbg_mux_sel,
  output logic [15:0] dbg_inst_src,
  output logic [15:0] dbg_inst_dest,
  output logic [15:0] dbg_reg_dest_val,
  output logic        dbg_reg_dest_wr,
  output logic        dbg_inst_bw
);

  typedef enum logic [1:0] {IDLE, HALT, SEL, DONE} state_t;

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(HALT_TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [TMO_W-1:0]  cnt_q, cnt_d;
  logic              fault;
  logic              wr_q, wr_d;
  logic [3:0]        addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic              keep_q;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic [15:0]       rdata_q, rdata_d;

  always_ff @(posedge mclk or negedge puc_n) begin
    if (!puc_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fault   = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (dbg_req) begin
          // R3 is the constant generator: writes are refused without touching the CPU
          if (dbg_wr && dbg_addr == 4'd3) begin
            state_d = DONE;
            fault   = 1'b1;
          end else begin
            state_d = HALT;
          end
        end
      end
      HALT: begin
        if (cpu_halted) begin
          state_d = SEL;
          cnt_d   = '0;
        end else if (cnt_q == TMO_LAST) begin
          state_d = DONE;
          fault   = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SEL:     state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (state_q == IDLE && dbg_req) begin
      wr_d    = dbg_wr;
      addr_d  = dbg_addr;
      wdata_d = dbg_wdata;
    end
    ack_d   = (state_d == DONE);
    err_d   = (state_d == DONE) && fault;
    rdata_d = (state_q == SEL && !wr_q) ? reg_src : rdata_q;
  end

  always_ff @(posedge mclk or negedge puc_n) begin
    if (!puc_n) begin
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      keep_q  <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      keep_q  <= dbg_halt_keep;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Register file controls come only from state and latched fields.
  always_comb begin
    dbg_busy         = (state_q != IDLE);
    dbg_mux_sel      = (state_q == SEL);
    dbg_halt_req     = (state_q == HALT || state_q == SEL) ? 1'b1 : keep_q;
    dbg_inst_src     = (state_q == SEL && !wr_q) ? (16'h0001 << addr_q) : 16'h0000;
    dbg_inst_dest    = (state_q == SEL &&  wr_q) ? (16'h0001 << addr_q) : 16'h0000;
    dbg_reg_dest_val = (state_q == SEL &&  wr_q) ? wdata_q : 16'h0000;
    dbg_reg_dest_wr  = (state_q == SEL &&  wr_q);
    dbg_inst_bw      = 1'b0;
    dbg_ack          = ack_q;
    dbg_err          = err_q;
    dbg_rdata        = rdata_q;
  end

endmodule

// File: doc/dbg_reg_ctrl.md
Name: dbg_reg_ctrl

Overview:
- Debug-side initiator for the CPU register file. It converts single debug requests ("read Rn" / "write Rn") into register-file control cycles.
- Sequence per request: halt the CPU, wait for halt acknowledge, take over the source/destination one-hot selects and write strobe for one cycle, capture or write 16-bit data, acknowledge.
- Sits between the debug interface and the register file control mux, in parallel with the execution unit.

Parameters:
HALT_TIMEOUT, 64, cycles allowed in HALT state for cpu_halted before the access aborts with error (min 2)
TMO_W, 7, width of the timeout counter (must satisfy 2^TMO_W > HALT_TIMEOUT)

Ports:
mclk  input  1  main system clock
puc_n  input  1  asynchronous active-low reset
dbg_req  input  1  single-cycle request pulse; sampled only in IDLE
dbg_wr  input  1  1 = write, 0 = read; latched with dbg_req
dbg_addr  input  4  register number R0..R15; latched with dbg_req
dbg_wdata  input  16  write data; latched with dbg_req
dbg_halt_keep  input  1  keep CPU halted after the access completes
dbg_ack  output  1  one-cycle completion pulse
dbg_err  output  1  error flag, valid while dbg_ack=1
dbg_rdata  output  16  read data; holds its value until the next successful read
dbg_busy  output  1  high in any state other than IDLE
cpu_halted  input  1  CPU frontend stopped; no execution-unit register access in flight
reg_src  input  16  register file source read data
dbg_halt_req  output  1  CPU halt request
dbg_mux_sel  output  1  1 = register file controls are driven by this block
dbg_inst_src  output  16  one-hot source select
dbg_inst_dest  output  16  one-hot destination select
dbg_reg_dest_val  output  16  write value
dbg_reg_dest_wr  output  1  write strobe
dbg_inst_bw  output  1  byte width; constant 0 (word access only)

Behaviour:
- Reset (puc_n=0, asynchronous): state=IDLE, counter=0. All outputs 0, including dbg_rdata=16'h0000 and dbg_halt_req=0.
- Reset mid-access: the access is dropped, no ack is issued, and halt is released immediately.
- States: IDLE, HALT, SEL, DONE.
- IDLE:
  - dbg_req=1 latches wr, addr and wdata.
  - Write to R3 (constant generator): go to DONE with err=1. No halt and no register access.
  - Otherwise go to HALT.
  - dbg_req outside IDLE is ignored; no queueing.
- HALT:
  - dbg_halt_req=1; the counter increments each cycle spent in HALT.
  - cpu_halted=1 at a clock edge: go to SEL, clear counter.
  - Counter reaches HALT_TIMEOUT-1 with cpu_halted still 0: go to DONE with err=1. If both occur on the same edge, cpu_halted wins.
- SEL (exactly one cycle):
  - dbg_halt_req=1 and dbg_mux_sel=1.
  - Read: dbg_inst_src=1<<addr, dbg_inst_dest=0, dbg_reg_dest_wr=0. reg_src is captured into dbg_rdata at the closing edge. R0 returns the PC; R2 returns the full SR.
  - Write: dbg_inst_dest=1<<addr, dbg_inst_src=0, dbg_reg_dest_val=wdata, dbg_reg_dest_wr=1. The register file updates on the closing edge. R0 write produces a PC software write. R1 bit0 is forced to 0 by the register file, not by this block.
  - Next state: DONE.
- DONE:
  - dbg_ack=1 for one cycle; dbg_err reflects the latched error; next state IDLE.
  - dbg_halt_req stays 1 only if dbg_halt_keep=1.
- Outside SEL: dbg_inst_src, dbg_inst_dest, dbg_reg_dest_val and dbg_reg_dest_wr are 0, and dbg_mux_sel=0.
- dbg_halt_req:
  - 1 in HALT and SEL.
  - In DONE and IDLE it equals dbg_halt_keep, registered, so it changes one cycle after dbg_halt_keep.
  - Held low during reset.
- Latency, with req at edge k and CPU already halted: SEL in cycle k+2, dbg_ack in cycle k+3. R3-write error: dbg_ack in cycle k+1.
- Registered outputs: dbg_ack, dbg_err, dbg_rdata. Select/strobe outputs are decoded from state plus latched fields only, never from live dbg_* inputs.
- dbg_rdata is unchanged by writes and by errored accesses.

Test Plan:
- Read R5=16'h1234, cpu_halted tied 1, pulse req (wr=0, addr=5):
  - SEL one cycle with dbg_inst_src=16'h0020.
  - dbg_ack at req+3 with dbg_rdata=16'h1234, err=0.
- Write R15 with 16'hBEEF:
  - SEL drives dbg_inst_dest=16'h8000, dbg_reg_dest_val=16'hBEEF, wr strobe for exactly 1 cycle.
  - A later read of R15 returns 16'hBEEF.
- Write R3 with 16'h5555:
  - dbg_ack at req+1 with err=1.
  - dbg_halt_req never asserts, no strobe, dbg_rdata unchanged.
- Timeout, HALT_TIMEOUT=8, cpu_halted held 0:
  - dbg_halt_req high 8 cycles, then dbg_ack with err=1, no SEL cycle.
  - Repeat with cpu_halted rising on the 8th HALT cycle: completes with err=0.
- Halt keep and reset:
  - dbg_halt_keep=1 across a read: dbg_halt_req stays 1 after ack; drop keep and it falls one cycle later.
  - Assert puc_n=0 during HALT: all outputs go 0 immediately, no ack after reset release.
- Ignored request and R1 write:
  - dbg_req pulsed while busy: no second ack, latched addr unchanged.
  - Write R1 with 16'h0203, then read R1: returns 16'h0202.
